// File: rtl/ram_banked.sv
// ram_banked: single-port request/acknowledge RAM built from a grid of
// 512x8 banks (C = WIDTH/8 columns, R = DEPTH/512 rows).
//
// Build option: define RAM_CLEAR_EN to compile in the post-reset clear
// sequencer, which writes zero to every bank location before the first access.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   req_i   request valid, held until ack_o
//   we_i    1 = write, 0 = read
//   be_i    per-byte write enables (ignored on reads)
//   adr_i   word address; [8:0] bank address, [AW-1:9] row select
//   dat_i   write data, byte b -> column b
//   dat_o   read data during a read ack, otherwise 0
//   ack_o   one-cycle completion pulse
//   busy_o  clear sequence running
module ram_banked #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned C     = WIDTH / 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [C-1:0]     be_i,
  input  logic [AW-1:0]    adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  output logic             busy_o
);

  localparam int unsigned R  = DEPTH / 512;
  localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   row_sel;

  // Bank control, shared address/data, per-row read data
  logic [R-1:0][C-1:0]     mac_cen;
  logic [R-1:0][C-1:0]     mac_wen;
  logic [8:0]              mac_adr;
  logic [WIDTH-1:0]        mac_din;
  logic [R-1:0][WIDTH-1:0] row_dout;

`ifdef RAM_CLEAR_EN
  logic [8:0] clr_q, clr_d;
`endif

  generate
    if (R > 1) begin : g_rowsel
      assign row_sel = adr_i[AW-1:9];
    end else begin : g_rowsel_one
      assign row_sel = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
`ifdef RAM_CLEAR_EN
      state_q <= S_CLEAR;
      clr_q   <= '0;
`else
      state_q <= S_IDLE;
`endif
      we_q    <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      row_q   <= row_d;
`ifdef RAM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    row_d   = row_q;
    mac_cen = '1;
    mac_wen = '0;
    mac_adr = adr_i[8:0];
    mac_din = dat_i;
`ifdef RAM_CLEAR_EN
    clr_d   = clr_q;
`endif
    case (state_q)
`ifdef RAM_CLEAR_EN
      S_CLEAR: begin
        // All banks written in parallel: one location per cycle, 512 cycles.
        mac_cen = '0;
        mac_wen = '1;
        mac_adr = clr_q;
        mac_din = '0;
        clr_d   = clr_q + 9'd1;
        if (clr_q == 9'd511) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_IDLE: begin
        if (req_i) begin
          state_d = S_ACK;
          we_d    = we_i;
          if (!we_i) begin
            row_d = row_sel;
          end
          for (int unsigned r = 0; r < R; r++) begin
            if (row_sel == RW'(r)) begin
              // Writes enable only the byte-enabled columns; reads enable all.
              mac_cen[r] = we_i ? ~be_i : '0;
              mac_wen[r] = {C{we_i}};
            end
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bank grid: each block models one 512x8 macro with active-low chip
  // enable, wen=1 write / wen=0 read, and a registered read port.
  generate
    for (genvar r = 0; r < int'(R); r++) begin : g_row
      for (genvar c = 0; c < int'(C); c++) begin : g_col
        logic [7:0] mem [512];
        logic [7:0] dout_q;

        always_ff @(posedge clk_i) begin
          if (!mac_cen[r][c]) begin
            if (mac_wen[r][c]) begin
              mem[mac_adr] <= mac_din[8*c +: 8];
            end else begin
              dout_q <= mem[mac_adr];
            end
          end
        end

        assign row_dout[r][8*c +: 8] = dout_q;
      end
    end
  endgenerate

  assign ack_o = (state_q == S_ACK);
  assign dat_o = (state_q == S_ACK && !we_q) ? row_dout[row_q] : '0;

`ifdef RAM_CLEAR_EN
  assign busy_o = (state_q == S_CLEAR);
`else
  assign busy_o = 1'b0;
`endif

endmodule
